// File: rtl/lane_move_ctrl.sv
// Lane move controller: vsync frame ticks, level-scaled move strobes,
// and the start/pause/collision game-state machine.
module lane_move_ctrl #(
  parameter int PERIOD_INIT      = 3,
  parameter int PERIOD_MIN       = 1,
  parameter int LEVEL_UP_MOVES   = 64,
  parameter int MAX_LEVEL        = 7,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  output logic       move,
  output logic       follower_reset,
  output logic [2:0] level,
  output logic [1:0] state
);

  localparam int PMAX =
    (PERIOD_INIT > PERIOD_MIN) ? PERIOD_INIT : PERIOD_MIN;
  localparam int FCW = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int MCW =
    (LEVEL_UP_MOVES > 1) ? $clog2(LEVEL_UP_MOVES) : 1;

  localparam logic VS_IDLE = (VSYNC_ACTIVE_LOW != 0);
  localparam logic [2:0] LVL_MAX = 3'(MAX_LEVEL);
  localparam logic [MCW-1:0] MC_LAST = MCW'(LEVEL_UP_MOVES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_HALT   = 2'b11
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_vsync_q;
  logic           r_armed;
  logic [FCW-1:0] r_frame_cnt;
  logic [MCW-1:0] r_move_cnt;
  logic [2:0]     r_level;
  logic           r_move;
  logic           r_frs;

  logic           w_vs_on;
  logic           w_vs_q_on;
  logic           w_tick;
  logic [FCW:0]   w_period;
  logic           w_last;
  logic           w_restart;
  logic           w_run_tick;
  logic           w_fire;

  // Edge detect on the asserted vsync level; r_armed blocks the
  // first post-reset cycle so a vsync already asserted is no edge.
  assign w_vs_on   = (vsync != VS_IDLE);
  assign w_vs_q_on = (r_vsync_q != VS_IDLE);
  assign w_tick    = w_vs_on & ~w_vs_q_on & r_armed;

  // Frames per move, clamped before subtracting so it never wraps.
  always_comb begin
    w_period = (FCW+1)'(PERIOD_MIN);
    if (PERIOD_INIT > int'(r_level) + PERIOD_MIN)
      w_period = (FCW+1)'(PERIOD_INIT - int'(r_level));
  end

  assign w_last =
    ({1'b0, r_frame_cnt} >= (w_period - (FCW+1)'(1)));

  // Next state plus the restart and count qualifiers.
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_run_tick  = 1'b0;
    unique case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_restart   = 1'b1;
        end
      end
      S_RUN: begin
        if (hit)
          w_state_nxt = S_HALT;
        else if (pause)
          w_state_nxt = S_PAUSED;
        else
          w_run_tick = w_tick;
      end
      S_PAUSED: begin
        if (hit)
          w_state_nxt = S_HALT;
        else if (!pause)
          w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_fire = w_run_tick & w_last;

  // Game state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // vsync history for the edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vsync_q <= VS_IDLE;
      r_armed   <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      r_armed   <= 1'b1;
    end
  end

  // Frame divider, move counter and saturating level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_move_cnt  <= '0;
      r_level     <= '0;
    end else if (w_restart) begin
      r_frame_cnt <= '0;
      r_move_cnt  <= '0;
      r_level     <= '0;
    end else if (w_fire) begin
      r_frame_cnt <= '0;
      if (r_move_cnt == MC_LAST) begin
        r_move_cnt <= '0;
        if (r_level < LVL_MAX)
          r_level <= r_level + 3'd1;
      end else begin
        r_move_cnt <= r_move_cnt + MCW'(1);
      end
    end else if (w_run_tick) begin
      r_frame_cnt <= r_frame_cnt + FCW'(1);
    end
  end

  // One-cycle strobes; restart and move are mutually exclusive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_move <= 1'b0;
      r_frs  <= 1'b0;
    end else begin
      r_move <= w_fire;
      r_frs  <= w_restart;
    end
  end

  assign move           = r_move;
  assign follower_reset = r_frs;
  assign level          = r_level;
  assign state          = r_state;

endmodule

// File: tb/tb_lane_move_ctrl.sv
// Bench for lane_move_ctrl: per-cycle game model driven by
// random frame lengths, plus directed scenario checks.
module tb_lane_move_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs = 1'b1;
  logic       start_i = 1'b0;
  logic       pause_i = 1'b0;
  logic       hit_i = 1'b0;
  logic       move;
  logic       follower_reset;
  logic [2:0] level;
  logic [1:0] state;

  int nvec = 0;
  int nerr = 0;
  int bad = 0;
  int dut_moves = 0;
  int dut_frs = 0;

  int m_state = 0;
  int m_frames = 0;
  int m_moves = 0;
  bit m_vsprev = 0;
  bit m_move = 0;
  bit m_fr = 0;

  lane_move_ctrl dut (
    .clk(clk),
    .reset(rst),
    .vsync(vs),
    .start(start_i),
    .pause(pause_i),
    .hit(hit_i),
    .move(move),
    .follower_reset(follower_reset),
    .level(level),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic int m_level();
    int l;
    l = m_moves / 64;
    return (l > 7) ? 7 : l;
  endfunction

  function automatic int m_period();
    int p;
    p = 3 - m_level();
    return (p < 1) ? 1 : p;
  endfunction

  task automatic m_reset();
    m_state = 0;
    m_frames = 0;
    m_moves = 0;
    m_vsprev = 0;
    m_move = 0;
    m_fr = 0;
  endtask

  // One clock: advance the game model, then sample the DUT.
  task automatic cyc();
    bit va;
    bit tk;
    @(posedge clk);
    va = (vs == 1'b0);
    tk = va && !m_vsprev;
    m_move = 0;
    m_fr = 0;
    if (rst) begin
      m_reset();
    end else begin
      case (m_state)
        0, 3: if (start_i) begin
          m_state = 1;
          m_moves = 0;
          m_frames = 0;
          m_fr = 1;
        end
        1: begin
          if (hit_i) m_state = 3;
          else if (pause_i) m_state = 2;
          else if (tk) begin
            if (m_frames + 1 >= m_period()) begin
              m_frames = 0;
              m_moves++;
              m_move = 1;
            end else begin
              m_frames++;
            end
          end
        end
        2: begin
          if (hit_i) m_state = 3;
          else if (!pause_i) m_state = 1;
        end
        default: m_state = 0;
      endcase
      m_vsprev = va;
    end
    #1;
    if (move !== m_move || follower_reset !== m_fr ||
        level !== 3'(m_level()) || state !== 2'(m_state) ||
        (move === 1'b1 && follower_reset === 1'b1))
      bad++;
    if (move === 1'b1) dut_moves++;
    if (follower_reset === 1'b1) dut_frs++;
  endtask

  task automatic frame(input int nd, input int na);
    vs = 1'b1;
    repeat (nd) cyc();
    vs = 1'b0;
    repeat (na) cyc();
  endtask

  task automatic frames(input int n);
    repeat (n) frame($urandom_range(2, 5), $urandom_range(1, 3));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vs = 1'b1;
    repeat (2) cyc();
    if (move !== 1'b0) begin
      nerr++; $display("FAIL rst_move: got %0d want 0", move);
    end
    nvec++;
    if (follower_reset !== 1'b0) begin
      nerr++; $display("FAIL rst_frs: got %0d want 0", follower_reset);
    end
    nvec++;
    if (level !== 3'd0) begin
      nerr++; $display("FAIL rst_level: got %0d want 0", level);
    end
    nvec++;
    if (state !== 2'd0) begin
      nerr++; $display("FAIL rst_state: got %0d want 0", state);
    end
    nvec++;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_idle();
    int b;
    b = dut_moves;
    frames(10);
    if (dut_moves - b !== 0) begin
      nerr++; $display("FAIL idle_moves: got %0d want 0", dut_moves - b);
    end
    nvec++;
    if (state !== 2'd0 || level !== 3'd0) begin
      nerr++;
      $display("FAIL idle_regs: got st=%0d lv=%0d want 0/0", state, level);
    end
    nvec++;
  endtask

  task automatic test_start();
    int b;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    if (follower_reset !== 1'b1 || state !== 2'd1) begin
      nerr++;
      $display("FAIL start_frs: got fr=%0d st=%0d want 1/1",
               follower_reset, state);
    end
    nvec++;
    cyc();
    if (follower_reset !== 1'b0) begin
      nerr++; $display("FAIL start_frs_len: got %0d want 0", follower_reset);
    end
    nvec++;
    b = dut_moves;
    frames(2);
    if (dut_moves - b !== 0) begin
      nerr++; $display("FAIL start_early: got %0d want 0", dut_moves - b);
    end
    nvec++;
    vs = 1'b1;
    repeat (3) cyc();
    vs = 1'b0;
    cyc();
    if (move !== 1'b1) begin
      nerr++; $display("FAIL move_lat: got %0d want 1", move);
    end
    nvec++;
    cyc();
    if (move !== 1'b0) begin
      nerr++; $display("FAIL move_len: got %0d want 0", move);
    end
    nvec++;
    frames(6);
    if (dut_moves - b !== 3) begin
      nerr++; $display("FAIL period3: got %0d want 3", dut_moves - b);
    end
    nvec++;
  endtask

  task automatic test_level();
    int b;
    int n;
    n = 0;
    while (m_moves < 64 && n < 400) begin frames(1); n++; end
    if (level !== 3'd1) begin
      nerr++; $display("FAIL level1: got %0d want 1", level);
    end
    nvec++;
    b = dut_moves;
    frames(4);
    if (dut_moves - b !== 2) begin
      nerr++; $display("FAIL period2: got %0d want 2", dut_moves - b);
    end
    nvec++;
    n = 0;
    while (m_moves < 448 && n < 1500) begin frames(1); n++; end
    if (level !== 3'd7) begin
      nerr++; $display("FAIL level7: got %0d want 7", level);
    end
    nvec++;
    b = dut_moves;
    frames(10);
    if (dut_moves - b !== 10) begin
      nerr++; $display("FAIL period1: got %0d want 10", dut_moves - b);
    end
    nvec++;
    n = 0;
    while (m_moves < 520 && n < 200) begin frames(1); n++; end
    if (level !== 3'd7) begin
      nerr++; $display("FAIL level_sat: got %0d want 7", level);
    end
    nvec++;
    if (bad !== 0) begin
      nerr++; $display("FAIL level_model: got %0d want 0 bad cycles", bad);
    end
    nvec++;
  endtask

  task automatic test_conflict();
    int b;
    int f;
    b = dut_moves;
    vs = 1'b1;
    repeat (3) cyc();
    vs = 1'b0;
    hit_i = 1'b1;
    pause_i = 1'b1;
    cyc();
    hit_i = 1'b0;
    pause_i = 1'b0;
    if (state !== 2'd3 || move !== 1'b0) begin
      nerr++;
      $display("FAIL hit_tick: got st=%0d mv=%0d want 3/0", state, move);
    end
    nvec++;
    frames(3);
    if (dut_moves - b !== 0) begin
      nerr++; $display("FAIL halt_moves: got %0d want 0", dut_moves - b);
    end
    nvec++;
    f = dut_frs;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    cyc();
    if (state !== 2'd1 || level !== 3'd0 || dut_frs - f !== 1) begin
      nerr++;
      $display("FAIL restart: got st=%0d lv=%0d fr=%0d want 1/0/1",
               state, level, dut_frs - f);
    end
    nvec++;
  endtask

  task automatic test_pause();
    int b;
    int n;
    frames(1);
    pause_i = 1'b1;
    cyc();
    b = dut_moves;
    frames(5);
    if (state !== 2'd2 || dut_moves - b !== 0) begin
      nerr++;
      $display("FAIL paused: got st=%0d mv=%0d want 2/0",
               state, dut_moves - b);
    end
    nvec++;
    pause_i = 1'b0;
    cyc();
    if (state !== 2'd1) begin
      nerr++; $display("FAIL unpause: got %0d want 1", state);
    end
    nvec++;
    n = 0;
    while (dut_moves == b && n < 10) begin frames(1); n++; end
    if (n !== 2) begin
      nerr++; $display("FAIL resume_ticks: got %0d want 2", n);
    end
    nvec++;
  endtask

  task automatic test_async_reset();
    int n;
    int b;
    n = 0;
    while (move !== 1'b1 && n < 10) begin
      vs = 1'b1;
      repeat (3) cyc();
      vs = 1'b0;
      cyc();
      n++;
    end
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    if (move !== 1'b0 || state !== 2'd0) begin
      nerr++;
      $display("FAIL async_rst: got mv=%0d st=%0d want 0/0", move, state);
    end
    nvec++;
    repeat (2) cyc();
    rst = 1'b0;
    b = dut_moves;
    repeat (6) cyc();
    if (state !== 2'd0 || dut_moves - b !== 0) begin
      nerr++;
      $display("FAIL post_rst: got st=%0d mv=%0d want 0/0",
               state, dut_moves - b);
    end
    nvec++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      start_i = ($urandom_range(0, 9) == 0);
      pause_i = ($urandom_range(0, 5) == 0);
      hit_i = ($urandom_range(0, 19) == 0);
      frames(1);
    end
    start_i = 1'b0;
    pause_i = 1'b0;
    hit_i = 1'b0;
    cyc();
    if (bad !== 0) begin
      nerr++; $display("FAIL random_model: got %0d want 0 bad cycles", bad);
    end
    nvec++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_start();
    test_level();
    test_conflict();
    test_pause();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
